// File: rtl/imu_spi_seq.sv
// rtl/imu_spi_seq.sv - IMU SPI sequencer: power-up config writes, then INT-driven rate reads
// Optional feature macro SPI_TIMEOUT_EN: WT-state timeout with sticky err output.
module imu_spi_seq #(
  parameter int PWRUP_W = 16,
  parameter int TO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  input  logic        INT,
  output logic        init_done,
  output logic [15:0] rate_a,
  output logic [15:0] rate_b,
  output logic        vld
`ifdef SPI_TIMEOUT_EN
  ,output logic       err
`endif
);

  typedef enum logic [2:0] {PWRUP, WR_GO, WR_WT, IDLE, RD_GO, RD_WT, PUB} state_t;

  state_t               state_q;
  logic [PWRUP_W-1:0]   pwr_cnt_q;
  logic [1:0]           idx_q;
  logic                 first_q;
  logic                 pend_q;
  logic                 int_s1_q, int_s2_q, int_s3_q;
  logic [7:0]           b0_q, b1_q, b2_q;
  logic                 spi_wrt_q, init_done_q, vld_q;
  logic [15:0]          spi_cmd_q, rate_a_q, rate_b_q;
  logic                 int_rise;
  logic                 unused_rd_hi;

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC) + 1;
  // Trips on the last WT cycle so err becomes visible TO_CYC cycles after the wrt pulse.
  localparam logic [TW-1:0] TO_LIM = TW'(TO_CYC - 2);
  logic [TW-1:0] to_cnt_q;
  logic          err_q;
`else
  localparam int unused_to_cyc = TO_CYC;
`endif

  function automatic logic [15:0] wr_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1053;
      2'd2:    return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'hA200;
      2'd1:    return 16'hA300;
      2'd2:    return 16'hA600;
      default: return 16'hA700;
    endcase
  endfunction

  assign int_rise     = int_s2_q & ~int_s3_q;
  assign unused_rd_hi = ^spi_rd_data[15:8];

  // Command outputs are loaded on entry to a GO state so spi_wrt coincides with the GO cycle
  // and the stale done level overlaps only the first WT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      pwr_cnt_q   <= '0;
      idx_q       <= 2'd0;
      first_q     <= 1'b0;
      pend_q      <= 1'b0;
      int_s1_q    <= 1'b0;
      int_s2_q    <= 1'b0;
      int_s3_q    <= 1'b0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      b2_q        <= 8'h00;
      spi_wrt_q   <= 1'b0;
      spi_cmd_q   <= 16'h0000;
      init_done_q <= 1'b0;
      rate_a_q    <= 16'h0000;
      rate_b_q    <= 16'h0000;
      vld_q       <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      int_s1_q  <= INT;
      int_s2_q  <= int_s1_q;
      int_s3_q  <= int_s2_q;
      spi_wrt_q <= 1'b0;
      vld_q     <= 1'b0;
      if (int_rise && init_done_q && state_q != IDLE) pend_q <= 1'b1;

      case (state_q)
        PWRUP: begin
          if (&pwr_cnt_q) begin
            state_q   <= WR_GO;
            idx_q     <= 2'd0;
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= wr_cmd(2'd0);
          end else begin
            pwr_cnt_q <= pwr_cnt_q + 1'b1;
          end
        end
        WR_GO: begin
          state_q  <= WR_WT;
          first_q  <= 1'b1;
`ifdef SPI_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        WR_WT: begin
          first_q <= 1'b0;
          if (!first_q && spi_done) begin
            if (idx_q != 2'd3) begin
              idx_q     <= idx_q + 2'd1;
              state_q   <= WR_GO;
              spi_wrt_q <= 1'b1;
              spi_cmd_q <= wr_cmd(idx_q + 2'd1);
            end else begin
              init_done_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
`ifdef SPI_TIMEOUT_EN
          else if (to_cnt_q == TO_LIM) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
`endif
        end
        IDLE: begin
          if ((int_rise && init_done_q) || pend_q) begin
            pend_q    <= 1'b0;
            idx_q     <= 2'd0;
            state_q   <= RD_GO;
            spi_wrt_q <= 1'b1;
            spi_cmd_q <= rd_cmd(2'd0);
          end
        end
        RD_GO: begin
          state_q  <= RD_WT;
          first_q  <= 1'b1;
`ifdef SPI_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        RD_WT: begin
          first_q <= 1'b0;
          if (!first_q && spi_done) begin
            case (idx_q)
              2'd0:    b0_q <= spi_rd_data[7:0];
              2'd1:    b1_q <= spi_rd_data[7:0];
              2'd2:    b2_q <= spi_rd_data[7:0];
              default: ;
            endcase
            if (idx_q != 2'd3) begin
              idx_q     <= idx_q + 2'd1;
              state_q   <= RD_GO;
              spi_wrt_q <= 1'b1;
              spi_cmd_q <= rd_cmd(idx_q + 2'd1);
            end else begin
              // Last byte goes straight from the bus so both words publish together.
              state_q  <= PUB;
              rate_a_q <= {b1_q, b0_q};
              rate_b_q <= {spi_rd_data[7:0], b2_q};
              vld_q    <= 1'b1;
            end
          end
`ifdef SPI_TIMEOUT_EN
          else if (to_cnt_q == TO_LIM) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            b0_q    <= 8'h00;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
`endif
        end
        PUB: state_q <= IDLE;
        default: state_q <= PWRUP;
      endcase
    end
  end

  assign spi_wrt   = spi_wrt_q;
  assign spi_cmd   = spi_cmd_q;
  assign init_done = init_done_q;
  assign rate_a    = rate_a_q;
  assign rate_b    = rate_b_q;
  assign vld       = vld_q;
`ifdef SPI_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_imu_spi_seq.sv
// tb/tb_imu_spi_seq.sv - scoreboard bench for imu_spi_seq with an SPI slave model
`timescale 1ns/1ps
module tb_imu_spi_seq;
  localparam int PW  = 6;
  localparam int TOC = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        spi_done = 1'b0;
  logic        INT = 1'b0;
  logic [15:0] spi_rd_data = 16'h0000;
  logic        spi_wrt, init_done, vld;
  logic [15:0] spi_cmd, rate_a, rate_b;
`ifdef SPI_TIMEOUT_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int vld_cnt = 0;
  int wrt_cnt = 0;
  int last_wrt = -10;
  int last_vld = -10;
  int wr3_done_cyc = -10;
  int rd3_done_cyc = -10;
  int lat = 40;
  bit directed = 1'b1;
  bit stuck = 1'b0;
  bit chk_gap = 1'b0;
  logic [7:0]  rb [4];
  logic [7:0]  dir_b [4];
  logic [15:0] exp_cmd [$];
  logic [31:0] exp_rate [$];

  imu_spi_seq #(.PWRUP_W(PW), .TO_CYC(TOC)) dut (
    .clk(clk), .rst_n(rst_n), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data), .INT(INT),
    .init_done(init_done), .rate_a(rate_a), .rate_b(rate_b), .vld(vld)
`ifdef SPI_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int reg_idx(input logic [15:0] c);
    case (c[15:8])
      8'hA2:   return 0;
      8'hA3:   return 1;
      8'hA6:   return 2;
      default: return 3;
    endcase
  endfunction

  // SPI slave: done stays high through the cycle after wrt, drops, then rises lat cycles after wrt.
  initial begin : slave
    int cnt;
    bit busy;
    logic [15:0] cur;
    busy = 1'b0; cnt = 0; cur = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 1'b0;
        spi_done = 1'b0;
      end else if (spi_wrt) begin
        cur = spi_cmd; busy = 1'b1; cnt = 0;
        if (cur[15:12] == 4'hA) begin
          rb[reg_idx(cur)] = directed ? dir_b[reg_idx(cur)] : 8'($urandom_range(0, 255));
          if (reg_idx(cur) == 3) exp_rate.push_back({rb[1], rb[0], rb[3], rb[2]});
        end
      end else if (busy) begin
        cnt++;
        if (cnt == 2) spi_done = 1'b0;
        if (cnt >= lat && !stuck) begin
          busy = 1'b0;
          spi_done = 1'b1;
          spi_rd_data = {8'($urandom_range(0, 255)), (cur[15:12] == 4'hA) ? rb[reg_idx(cur)] : 8'h00};
          if (cur == 16'h1460) wr3_done_cyc = cyc;
          if (cur == 16'hA700) rd3_done_cyc = cyc;
        end
      end
    end
  end

  initial begin : monitor
    logic [15:0] ec;
    logic [31:0] er;
    bit pv, pi;
    pv = 1'b0; pi = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_wrt) begin
        chk("wrt_spacing_ok", 32'(cyc - last_wrt >= 2), 32'd1);
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wrt: got cmd %h, none expected", spi_cmd);
        end else begin
          ec = exp_cmd.pop_front();
          chk("spi_cmd", spi_cmd, ec);
        end
        if (chk_gap && spi_cmd == 16'hA200) begin
          chk("pending_restart_latency", cyc - last_vld, 2);
          chk_gap = 1'b0;
        end
        last_wrt = cyc;
        wrt_cnt++;
      end
      if (vld) begin
        chk("vld_width", pv, 1'b0);
        if (exp_rate.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_vld: got %h/%h, none expected", rate_a, rate_b);
        end else begin
          er = exp_rate.pop_front();
          chk("rates", {rate_a, rate_b}, er);
        end
        chk("vld_latency", cyc - rd3_done_cyc, 1);
        vld_cnt++;
        last_vld = cyc;
      end
      if (init_done && !pi) chk("init_done_latency", cyc - wr3_done_cyc, 1);
      pv = vld;
      pi = init_done;
    end
  end

  task automatic push_wr();
    exp_cmd.push_back(16'h0D02); exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150); exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_rd();
    exp_cmd.push_back(16'hA200); exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hA600); exp_cmd.push_back(16'hA700);
  endtask

  task automatic pulse_int(input int w);
    @(negedge clk); INT = 1'b1;
    repeat (w) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic check_first_wrt();
    int t;
    t = 0;
    while (!spi_wrt && t < (2 ** PW) + 20) begin @(negedge clk); t++; end
    chk("pwrup_wait", cyc - rel_cyc, 2 ** PW);
  endtask

  task automatic wait_init();
    int t;
    t = 0;
    while (!init_done && t < 400) begin @(negedge clk); t++; end
    chk("init_done", init_done, 1'b1);
  endtask

  task automatic wait_vld(input int n, input int bound);
    int t;
    t = 0;
    while (vld_cnt < n && t < bound) begin @(negedge clk); t++; end
    chk("vld_count", vld_cnt, n);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_spi_wrt"}, spi_wrt, 1'b0);
    chk({tag, "_spi_cmd"}, spi_cmd, 16'h0000);
    chk({tag, "_init_done"}, init_done, 1'b0);
    chk({tag, "_rate_a"}, rate_a, 16'h0000);
    chk({tag, "_rate_b"}, rate_b, 16'h0000);
    chk({tag, "_vld"}, vld, 1'b0);
`ifdef SPI_TIMEOUT_EN
    chk({tag, "_err"}, err, 1'b0);
`endif
  endtask

  initial begin : stim
    int base, t;
    dir_b[0] = 8'h34; dir_b[1] = 8'h12; dir_b[2] = 8'hCD; dir_b[3] = 8'hAB;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    release_reset();

    // INT during power-up must be ignored entirely
    repeat (10) @(negedge clk);
    pulse_int(3);
    push_wr();
    check_first_wrt();
    wait_init();
    repeat (40) @(negedge clk);
    chk("no_read_before_int", wrt_cnt, 4);

    // directed read sequence
    base = vld_cnt;
    push_rd();
    pulse_int(2);
    wait_vld(base + 1, 400);
    chk("rate_a_directed", rate_a, 16'h1234);
    chk("rate_b_directed", rate_b, 16'hABCD);
    directed = 1'b0;

    // two edges during a sequence: one pending, one dropped
    repeat (10) @(negedge clk);
    base = vld_cnt;
    push_rd(); push_rd();
    pulse_int(2);
    repeat (60) @(negedge clk);
    chk_gap = 1'b1;
    pulse_int(2);
    repeat (20) @(negedge clk);
    pulse_int(2);
    wait_vld(base + 2, 1200);
    repeat (250) @(negedge clk);
    chk("extra_edge_dropped", vld_cnt, base + 2);
    chk("cmd_queue_drained", exp_cmd.size(), 0);

    // randomized read sequences
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(3, 45);
      base = vld_cnt;
      push_rd();
      pulse_int($urandom_range(1, 5));
      wait_vld(base + 1, 4 * 50 + 40);
      repeat ($urandom_range(2, 20)) @(negedge clk);
    end

    // reset during the third read's wait
    lat = 40;
    push_rd();
    pulse_int(2);
    t = 0;
    while (!(spi_wrt && spi_cmd == 16'hA600) && t < 400) begin @(negedge clk); t++; end
    chk("reached_third_read", spi_cmd, 16'hA600);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    chk("reads_left_at_reset", exp_cmd.size(), 1);
    chk("no_rate_at_reset", exp_rate.size(), 0);
    exp_cmd.delete();
    repeat (3) @(negedge clk);
    release_reset();
    push_wr();
    check_first_wrt();
    wait_init();
    base = vld_cnt;
    push_rd();
    pulse_int(2);
    wait_vld(base + 1, 400);

`ifdef SPI_TIMEOUT_EN
    repeat (10) @(negedge clk);
    stuck = 1'b1;
    base = vld_cnt;
    exp_cmd.push_back(16'hA200);
    pulse_int(2);
    t = 0;
    while (!err && t < TOC + 200) begin @(negedge clk); t++; end
    chk("err_set", err, 1'b1);
    chk("timeout_latency", cyc - last_wrt, TOC);
    repeat (50) @(negedge clk);
    chk("no_vld_after_timeout", vld_cnt, base);
`endif

    chk("exp_cmd_empty", exp_cmd.size(), 0);
    chk("exp_rate_empty", exp_rate.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
